// File: rtl/func_unit.sv
// Register-file function unit: single-cycle ALU/shift ops plus a
// WIDTH-cycle shift-and-add unsigned multiplier sharing one result register.
module func_unit #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FS,
  input  logic             START,
  output logic [WIDTH-1:0] F,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] FS_MUL = 4'b1111;

  state_t               state_reg;
  logic [WIDTH-1:0]     f_reg;
  logic                 v_reg, c_reg, n_reg, z_reg, busy_reg, done_reg;
  logic [2*WIDTH-1:0]   acc_reg, mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [CNT_W-1:0]     count_reg;

  logic [WIDTH-1:0]     b_op;
  logic                 cin;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     alu_f;
  logic                 alu_v, alu_c;
  logic [2*WIDTH-1:0]   addend, acc_next;
  logic                 prod_hi_nz;

  // Second adder operand and carry-in for the arithmetic group.
  always_comb begin
    b_op = '0;
    cin  = 1'b0;
    unique case (FS[2:0])
      3'b000: ;
      3'b001: cin = 1'b1;
      3'b010: b_op = B;
      3'b011: begin b_op = B;  cin = 1'b1; end
      3'b100: b_op = ~B;
      3'b101: begin b_op = ~B; cin = 1'b1; end
      3'b110: b_op = '1;
      3'b111: ;
    endcase
    sum = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    alu_f = '0;
    alu_v = 1'b0;
    alu_c = 1'b0;
    if (!FS[3]) begin
      alu_f = sum[WIDTH-1:0];
      alu_c = sum[WIDTH];
      alu_v = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    end else begin
      unique case (FS[2:0])
        3'b000: alu_f = A & B;
        3'b001: alu_f = A | B;
        3'b010: alu_f = A ^ B;
        3'b011: alu_f = ~A;
        3'b100: alu_f = B;
        3'b101: begin alu_f = B >> 1; alu_c = B[0];       end
        3'b110: begin alu_f = B << 1; alu_c = B[WIDTH-1]; end
        3'b111: ;
      endcase
    end
  end

  // Partial product for this step: the shifted multiplicand gated by the
  // current multiplier LSB.
  generate
    for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign acc_next   = acc_reg + addend;
  assign prod_hi_nz = |acc_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg  <= IDLE;
      f_reg      <= '0;
      v_reg      <= 1'b0;
      c_reg      <= 1'b0;
      n_reg      <= 1'b0;
      z_reg      <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (START) begin
            if (FS == FS_MUL) begin
              state_reg  <= MUL;
              busy_reg   <= 1'b1;
              acc_reg    <= '0;
              mcand_reg  <= {{WIDTH{1'b0}}, A};
              mplier_reg <= B;
              count_reg  <= '0;
            end else begin
              f_reg    <= alu_f;
              v_reg    <= alu_v;
              c_reg    <= alu_c;
              n_reg    <= alu_f[WIDTH-1];
              z_reg    <= (alu_f == '0);
              done_reg <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          // The accumulator stays internal; F only ever sees the final product.
          if (count_reg == CNT_W'(WIDTH-1)) begin
            f_reg     <= acc_next[WIDTH-1:0];
            v_reg     <= 1'b0;
            c_reg     <= prod_hi_nz;
            n_reg     <= acc_next[WIDTH-1];
            z_reg     <= (acc_next[WIDTH-1:0] == '0);
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign F    = f_reg;
  assign V    = v_reg;
  assign C    = c_reg;
  assign N    = n_reg;
  assign Z    = z_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;

endmodule

// File: tb/tb_func_unit.sv
// Directed scenarios plus randomized operations against an arithmetic
// reference model of the function unit (WIDTH=16).
module tb_func_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] A, B;
  logic [3:0]  FS;
  logic        START;
  logic [15:0] F;
  logic        V, C, N, Z, BUSY, DONE;

  int checks = 0;
  int failures = 0;

  func_unit #(.WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .FS(FS), .START(START),
    .F(F), .V(V), .C(C), .N(N), .Z(Z), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic void model(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] f, output logic v, output logic c);
    logic [15:0] op2;
    int          ci, full, exact;
    longint      p;
    f = '0; v = 1'b0; c = 1'b0;
    op2 = '0; ci = 0;
    if (fs < 4'd8) begin
      case (fs)
        4'd1: ci = 1;
        4'd2: op2 = b;
        4'd3: begin op2 = b; ci = 1; end
        4'd4: op2 = ~b;
        4'd5: begin op2 = ~b; ci = 1; end
        4'd6: op2 = 16'hFFFF;
        default: ;
      endcase
      full  = int'(a) + int'(op2) + ci;
      exact = int'($signed(a)) + int'($signed(op2)) + ci;
      f = full[15:0];
      c = full[16];
      v = (exact > 32767) || (exact < -32768);
    end else begin
      case (fs)
        4'd8:  f = a & b;
        4'd9:  f = a | b;
        4'd10: f = a ^ b;
        4'd11: f = ~a;
        4'd12: f = b;
        4'd13: begin f = b / 2; c = (b % 2) != 0; end
        4'd14: begin f = 16'(int'(b) * 2); c = (b >= 16'h8000); end
        default: begin
          p = longint'(a) * longint'(b);
          f = 16'(p % 65536);
          c = (p >= 65536);
        end
      endcase
    end
  endfunction

  task automatic issue(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
    FS = fs; A = a; B = b; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  logic [15:0] ef, held_f, ra, rb;
  logic        ev, ec;
  logic [3:0]  rfs;
  int          lat;

  initial begin
    RESET = 1'b0; START = 1'b1; FS = 4'b0010; A = 16'h7FFF; B = 16'h0001;
    tick();
    tick();
    chk("rst_F", F, 0);
    chk("rst_flags", {V, C, N, Z}, 0);
    chk("rst_busy_done", {BUSY, DONE}, 0);

    // START already high on the first released edge must be accepted.
    RESET = 1'b1;
    tick();
    START = 1'b0;
    chk("add_ovf_F", F, 16'h8000);
    chk("add_ovf_VCNZ", {V, C, N, Z}, 4'b1010);
    chk("add_ovf_done", DONE, 1);
    tick();
    chk("done_drop", DONE, 0);
    chk("F_hold", F, 16'h8000);

    issue(4'b0101, 16'h0005, 16'h0005);
    chk("sub_F", F, 16'h0000);
    chk("sub_VCNZ", {V, C, N, Z}, 4'b0101);
    issue(4'b0110, 16'h0000, 16'h1234);
    chk("dec_F", F, 16'hFFFF);
    chk("dec_VCNZ", {V, C, N, Z}, 4'b0010);

    issue(4'b1110, 16'h0000, 16'h8001);
    chk("shl_F", F, 16'h0002);
    chk("shl_C", C, 1);
    issue(4'b1101, 16'h0000, 16'h0003);
    chk("shr_F", F, 16'h0001);
    chk("shr_C", C, 1);

    // Multiply with START pulses and operand changes while busy.
    issue(4'b1111, 16'h0100, 16'h0100);
    lat = 0;
    while (!DONE && lat < 40) begin
      chk("mul_busy", BUSY, 1);
      chk("mul_F_hold", F, 16'h0001);
      START = lat[0]; FS = 4'b0001; A = 16'h1111; B = 16'h2222;
      tick();
      lat++;
    end
    START = 1'b0;
    chk("mul_lat", lat, 16);
    chk("mul_F", F, 16'h0000);
    chk("mul_VCNZ", {V, C, N, Z}, 4'b0101);
    chk("mul_busy_end", BUSY, 0);
    tick();
    chk("mul_single_done", DONE, 0);
    chk("mul_F_after", F, 16'h0000);

    // Reset in the middle of a multiply.
    issue(4'b1111, 16'd300, 16'd200);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_busy", BUSY, 1);
    RESET = 1'b0; START = 1'b1;
    tick();
    RESET = 1'b1; START = 1'b0;
    chk("abort_F", F, 0);
    chk("abort_flags", {V, C, N, Z}, 0);
    chk("abort_busy_done", {BUSY, DONE}, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("abort_no_done", {BUSY, DONE}, 0);
    end
    issue(4'b1111, 16'd12, 16'd11);
    lat = 0;
    while (!DONE && lat < 40) begin
      tick();
      lat++;
    end
    chk("mul2_lat", lat, 16);
    chk("mul2_F", F, 16'd132);
    chk("mul2_C", C, 0);

    // Back-to-back single-cycle ops.
    FS = 4'b0001; A = 16'h0000; START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b_done", DONE, 1);
      chk("b2b_F", F, 16'h0001);
    end
    START = 1'b0;
    tick();
    chk("b2b_done_drop", DONE, 0);

    // Randomized operations.
    for (int t = 0; t < 60; t++) begin
      rfs = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (t % 6)
        0: ra = 16'h0000;
        1: rb = 16'hFFFF;
        2: ra = 16'h8000;
        3: ra = 16'h7FFF;
        default: ;
      endcase
      model(rfs, ra, rb, ef, ev, ec);
      held_f = F;
      issue(rfs, ra, rb);
      lat = 0;
      while (!DONE && lat < 40) begin
        chk("rand_busy", BUSY, 1);
        chk("rand_F_hold", F, held_f);
        A = 16'($urandom); B = 16'($urandom); FS = 4'($urandom);
        START = 1'($urandom_range(0, 1));
        tick();
        lat++;
      end
      START = 1'b0;
      chk("rand_lat", lat, (rfs == 4'b1111) ? 16 : 0);
      chk("rand_F", F, ef);
      chk("rand_VC", {V, C}, {ev, ec});
      chk("rand_NZ", {N, Z}, {ef[15], ef == 16'h0000});
      chk("rand_busy_end", BUSY, 0);
    end

    tick();
    chk("final_done_low", DONE, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
